hash_job_scheduler: RTL

HASH_JOB_SCHEDULER -- requirements
Module: hash_job_scheduler

---
 rtl/hash_job_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/hash_job_scheduler.sv
// hash_job_scheduler
// Arbitrates three word-hash requesters onto one hash engine. Each job runs
// through the following states:
//   IDLE    -> a round-robin grant is latched
//   START   -> the engine is launched
//   WAIT    -> the engine's completion is awaited, with a timeout
//   DELIVER -> the captured hash is held until the consumer accepts it
//
// Handshake: Result/ResultValid follow valid/ready semantics. ResultValid
// rises with the capture and then stays high, with Result stable, until an
// edge where ResultReady=1; that edge is the transfer. Ack is the same-cycle
// image of the transfer, returned to the granted requester.
//
// Ports:
//   Clock, Reset      rising-edge clock; asynchronous active-high reset
//   Req[2:0]          level requests, held by each requester until its Ack
//   WordSel[2:0]      one-hot word select to the engine (000 when idle)
//   HashStart         one-cycle launch pulse (the START state)
//   HashDone, HashZ   engine completion flag and 64-bit hash value
//   Result[63:0]      captured hash of the granted word
//   ResultValid       Result is available; ResultReady accepts it
//   Ack[2:0]          one-cycle completion pulse to the granted requester
//   Busy              scheduler not idle
//   Error             one-cycle pulse when a job is aborted on timeout
module hash_job_scheduler #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [2:0]  Req,
    output logic [2:0]  WordSel,
    output logic        HashStart,
    input  logic        HashDone,
    input  logic [63:0] HashZ,
    output logic [63:0] Result,
    output logic        ResultValid,
    input  logic        ResultReady,
    output logic [2:0]  Ack,
    output logic        Busy,
    output logic        Error
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  ptr;       // one-hot: requester searched first
    logic [2:0]  grant;     // one-hot: requester owning the current job
    logic [2:0]  pick;      // round-robin choice from the live Req
    logic [2:0]  grant_rot; // requester after the granted one
    logic [7:0]  wait_cnt;
    logic        timeout;
    logic        accept;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    // Search starts at the pointer bit and walks upward, wrapping 2 -> 0.
    always_comb begin
        pick = 3'b000;
        case (ptr)
            3'b010:  pick = Req[1] ? 3'b010 : Req[2] ? 3'b100 : Req[0] ? 3'b001 : 3'b000;
            3'b100:  pick = Req[2] ? 3'b100 : Req[0] ? 3'b001 : Req[1] ? 3'b010 : 3'b000;
            default: pick = Req[0] ? 3'b001 : Req[1] ? 3'b010 : Req[2] ? 3'b100 : 3'b000;
        endcase
    end

    assign grant_rot = {grant[1:0], grant[2]};
    assign timeout   = (state == S_WAIT) && !HashDone && (wait_cnt == WAIT_LAST);
    assign accept    = (state == S_DELIVER) && ResultValid && ResultReady;

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (Req != 3'b000) state_nx = S_START;
            S_START:   state_nx = S_WAIT;
            S_WAIT:    if (HashDone)      state_nx = S_DELIVER;
                       else if (timeout)  state_nx = S_IDLE;
            S_DELIVER: if (accept)        state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        HashStart = (state == S_START);
        Busy      = (state != S_IDLE);
        WordSel   = (state != S_IDLE) ? grant : 3'b000;
        Ack       = accept ? grant : 3'b000;
    end

    // Job datapath: grant, pointer, wait counter, captured result, error pulse.
    // Req is looked at only in IDLE, so a withdrawn request still completes.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ptr         <= 3'b001;
            grant       <= 3'b000;
            wait_cnt    <= 8'd0;
            Result      <= 64'd0;
            ResultValid <= 1'b0;
            Error       <= 1'b0;
        end else begin
            Error <= timeout;
            case (state)
                S_IDLE: begin
                    if (Req != 3'b000) grant <= pick;
                end
                S_START: begin
                    wait_cnt <= 8'd0;
                end
                S_WAIT: begin
                    if (HashDone) begin
                        Result      <= HashZ;
                        ResultValid <= 1'b1;
                    end else if (timeout) begin
                        ptr <= grant_rot;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DELIVER: begin
                    if (accept) begin
                        ResultValid <= 1'b0;
                        ptr         <= grant_rot;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
